noc_axis_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter. Shares one NoC mesh injection port (one tile's axis_in_* set) among NUM_IN local AXI-Stream masters, e.g. two num_gen producers on one tile.
- Holds the grant from the first beat to the TLAST beat, so packets never interleave in the mesh.
- Sits in the user clock domain, between tile-local producers and the axis_mesh input.

---
 rtl/noc_axis_rr_arbiter.sv | 119 +++++++++++
 tb/tb_noc_axis_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_axis_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one mesh injection port from NUM_IN
// AXI-Stream masters; the grant is held from the first beat through TLAST.
module noc_axis_rr_arbiter #(
  parameter int NUM_IN    = 2,
  parameter int TDATAW    = 32,
  parameter int TDESTW    = 4,
  parameter int PKT_CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_IN-1:0]        AXIS_S_TVALID,
  output logic [NUM_IN-1:0]        AXIS_S_TREADY,
  input  logic [NUM_IN*TDATAW-1:0] AXIS_S_TDATA,
  input  logic [NUM_IN-1:0]        AXIS_S_TLAST,
  input  logic [NUM_IN*TDESTW-1:0] AXIS_S_TDEST,
  output logic                     AXIS_M_TVALID,
  input  logic                     AXIS_M_TREADY,
  output logic [TDATAW-1:0]        AXIS_M_TDATA,
  output logic                     AXIS_M_TLAST,
  output logic [TDESTW-1:0]        AXIS_M_TDEST,
  output logic [NUM_IN-1:0]        GRANT_O,
  output logic [PKT_CNT_W-1:0]     PKT_CNT
);

  localparam int          IDXW = $clog2(NUM_IN);
  localparam int unsigned N    = NUM_IN;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        ptr_q, ptr_d;
  logic [IDXW-1:0]        gnt_q, gnt_d;
  logic [NUM_IN-1:0]      gnt_oh_q, gnt_oh_d;
  logic [PKT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]        sel_idx;
  logic                   sel_found;
  logic                   beat_xfer;
  logic                   last_xfer;

  // First valid requester at or after ptr+1, wrapping modulo NUM_IN.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_found && AXIS_S_TVALID[IDXW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= IDXW'(NUM_IN - 1);
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    beat_xfer = (state_q == LOCKED) && AXIS_S_TVALID[gnt_q] && AXIS_M_TREADY;
    last_xfer = beat_xfer && AXIS_S_TLAST[gnt_q];
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_oh_d  = gnt_oh_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d  = LOCKED;
          gnt_d    = sel_idx;
          gnt_oh_d = NUM_IN'(1) << sel_idx;
        end
      end
      LOCKED: begin
        if (last_xfer) begin
          state_d  = IDLE;
          ptr_d    = gnt_q;
          gnt_oh_d = '0;
          cnt_d    = cnt_q + PKT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency pass-through of the granted requester; nothing when idle.
  always_comb begin
    AXIS_S_TREADY = '0;
    AXIS_M_TVALID = 1'b0;
    AXIS_M_TDATA  = '0;
    AXIS_M_TLAST  = 1'b0;
    AXIS_M_TDEST  = '0;
    if (state_q == LOCKED) begin
      AXIS_M_TVALID        = AXIS_S_TVALID[gnt_q];
      AXIS_M_TDATA         = AXIS_S_TDATA[gnt_q*TDATAW +: TDATAW];
      AXIS_M_TLAST         = AXIS_S_TLAST[gnt_q];
      AXIS_M_TDEST         = AXIS_S_TDEST[gnt_q*TDESTW +: TDESTW];
      AXIS_S_TREADY[gnt_q] = AXIS_M_TREADY;
    end
  end

  assign GRANT_O = gnt_oh_q;
  assign PKT_CNT = cnt_q;

endmodule

// File: tb/tb_noc_axis_rr_arbiter.sv
// Directed bench for noc_axis_rr_arbiter: per-requester beat queues drive the
// inputs, a cycle model predicts every output, literal checks pin the model.
module tb_noc_axis_rr_arbiter;

  localparam int NI  = 2;
  localparam int DW  = 32;
  localparam int DSW = 4;
  localparam int CW  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NI-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NI*DW-1:0]  s_tdata;
  logic [NI*DSW-1:0] s_tdest;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [DSW-1:0]    m_tdest;
  logic [NI-1:0]     grant;
  logic [CW-1:0]     pkt_cnt;

  always #5 CLK = ~CLK;

  noc_axis_rr_arbiter #(.NUM_IN(NI), .TDATAW(DW), .TDESTW(DSW), .PKT_CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready), .AXIS_S_TDATA(s_tdata),
    .AXIS_S_TLAST(s_tlast), .AXIS_S_TDEST(s_tdest),
    .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
    .AXIS_M_TLAST(m_tlast), .AXIS_M_TDEST(m_tdest),
    .GRANT_O(grant), .PKT_CNT(pkt_cnt)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [DSW-1:0] dest;
    logic           last;
    int             gap;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [DSW-1:0] dest;
    logic           last;
    int             cyc;
  } obeat_t;

  beat_t  srcq[NI][$];
  int     gap[NI];
  obeat_t out_q[$];
  bit     mr_pat[$];
  int     mr_idx = 0;
  int     total = 0, bad = 0, cyc = 0;

  // Model: current owner (-1 = idle), last finished requester, packet count.
  int  m_owner = -1, m_prev = NI - 1, m_cnt = 0;
  bit  m_ok = 1'b0;

  logic [NI-1:0] v_s, l_s, hs_s;
  logic          mr_s, rst_s;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (srcq[i].size() > 0 && gap[i] == 0) begin
        s_tvalid[i]           = 1'b1;
        s_tdata[i*DW +: DW]   = srcq[i][0].data;
        s_tdest[i*DSW +: DSW] = srcq[i][0].dest;
        s_tlast[i]            = srcq[i][0].last;
      end else begin
        s_tvalid[i]           = 1'b0;
        s_tdata[i*DW +: DW]   = '0;
        s_tdest[i*DSW +: DSW] = '0;
        s_tlast[i]            = 1'b0;
      end
    end
    m_tready = mr_pat[mr_idx % mr_pat.size()];
  endtask

  task automatic push(input int i, input logic [DW-1:0] d, input logic [DSW-1:0] dst,
                      input logic lst, input int g);
    beat_t b;
    b.data = d; b.dest = dst; b.last = lst; b.gap = g;
    if (srcq[i].size() == 0) gap[i] = g;
    srcq[i].push_back(b);
  endtask

  task automatic pkt(input int i, input logic [DW-1:0] base, input int n, input logic [DSW-1:0] dst);
    for (int b = 0; b < n; b++) push(i, base + DW'(b), dst, b == n - 1, 0);
  endtask

  task automatic flush();
    for (int i = 0; i < NI; i++) begin
      srcq[i].delete();
      gap[i] = 0;
    end
  endtask

  task automatic cycle();
    logic [NI-1:0]     eg;
    logic [DW+DSW:0]   ep;
    @(negedge CLK);
    if (m_ok) begin
      eg = (m_owner < 0) ? '0 : (NI'(1) << m_owner);
      ep = '0;
      if (m_owner >= 0)
        ep = {s_tdata[m_owner*DW +: DW], s_tlast[m_owner], s_tdest[m_owner*DSW +: DSW]};
      check("grant", grant, eg);
      check("m_tvalid", m_tvalid, (m_owner >= 0) ? s_tvalid[m_owner] : 1'b0);
      check("m_payload", {m_tdata, m_tlast, m_tdest}, ep);
      check("s_tready", s_tready, (m_owner >= 0 && m_tready) ? eg : '0);
      check("pkt_cnt", pkt_cnt, m_cnt);
    end
    if (m_tvalid === 1'b1 && m_tready) out_q.push_back('{m_tdata, m_tdest, m_tlast, cyc});
    v_s = s_tvalid; l_s = s_tlast; mr_s = m_tready; rst_s = RST;
    hs_s = s_tvalid & s_tready;
    @(posedge CLK);
    #1;
    cyc++;
    if (rst_s) begin
      m_owner = -1; m_prev = NI - 1; m_cnt = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= NI; k++) begin
          int c;
          c = (m_prev + k) % NI;
          if (m_owner < 0 && v_s[c]) m_owner = c;
        end
      end else if (v_s[m_owner] && mr_s && l_s[m_owner]) begin
        m_prev  = m_owner;
        m_owner = -1;
        m_cnt   = (m_cnt + 1) % (1 << CW);
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (hs_s[i] === 1'b1) begin
        void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) gap[i] = srcq[i][0].gap;
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    mr_idx++;
    drive();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    flush();
    drive();
    cycle();
    cycle();
    RST = 1'b0;
    drive();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (out_q.size() < n && b < budget) begin
      cycle();
      b++;
    end
    check({name, "_beats"}, out_q.size(), n);
    cycle();
    cycle();
  endtask

  task automatic set_pat(input bit a, input bit b, input bit c);
    mr_pat.delete();
    mr_pat.push_back(a); mr_pat.push_back(b); mr_pat.push_back(c);
    mr_idx = 0;
  endtask

  initial begin
    int c0;
    RST = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tdest = '0;
    flush();
    set_pat(1, 1, 1);
    drive();

    // Single requester, 4-beat packet.
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    out_q.delete();
    c0 = cyc;
    pkt(0, 32'h11, 4, 4'h1);
    drive();
    run_until(4, 20, "t1");
    if (out_q.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        check("t1_data", out_q[b].data, 32'h11 + b);
        check("t1_last", out_q[b].last, b == 3);
        check("t1_dest", out_q[b].dest, 4'h1);
      end
      check("t1_first_beat_cycle", out_q[0].cyc, c0 + 1);
      check("t1_back_to_back", out_q[3].cyc - out_q[0].cyc, 3);
    end
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_grant_idle", grant, 0);

    // Contention: two 3-beat packets from each requester.
    do_reset();
    out_q.delete();
    pkt(0, 32'hA0, 3, 4'h2); pkt(0, 32'hA3, 3, 4'h2);
    pkt(1, 32'hB0, 3, 4'h3); pkt(1, 32'hB3, 3, 4'h3);
    drive();
    run_until(12, 60, "t2");
    if (out_q.size() == 12) begin
      for (int p = 0; p < 4; p++)
        for (int b = 0; b < 3; b++)
          check("t2_order", out_q[p*3+b].data,
                ((p % 2) ? 32'hB0 : 32'hA0) + 32'((p / 2) * 3 + b));
      check("t2_bubble", out_q[3].cyc - out_q[2].cyc, 2);
    end
    check("t2_pkt_cnt", pkt_cnt, 4);

    // Backpressure 1,0,0 on a 4-beat packet from requester 1.
    do_reset();
    out_q.delete();
    set_pat(1, 0, 0);
    pkt(1, 32'hC1, 4, 4'h5);
    drive();
    run_until(4, 40, "t3");
    repeat (6) cycle();
    check("t3_no_dup", out_q.size(), 4);
    if (out_q.size() == 4)
      for (int b = 0; b < 4; b++) check("t3_data", out_q[b].data, 32'hC1 + b);
    check("t3_pkt_cnt", pkt_cnt, 1);

    // Source stall of 5 cycles after beat 2 while requester 1 waits.
    set_pat(1, 1, 1);
    do_reset();
    out_q.delete();
    push(0, 32'hD1, 4'h2, 0, 0); push(0, 32'hD2, 4'h2, 0, 0);
    push(0, 32'hD3, 4'h2, 0, 5); push(0, 32'hD4, 4'h2, 1, 0);
    pkt(1, 32'hE1, 2, 4'h3);
    drive();
    run_until(6, 40, "t4");
    if (out_q.size() == 6) begin
      check("t4_d1", out_q[0].data, 32'hD1);
      check("t4_d4", out_q[3].data, 32'hD4);
      check("t4_e1", out_q[4].data, 32'hE1);
      check("t4_stall_len", out_q[2].cyc - out_q[1].cyc, 6);
    end

    // 17 single-beat packets alternating requesters; 4-bit counter wraps.
    do_reset();
    out_q.delete();
    for (int j = 0; j < 9; j++) push(0, 32'h100 + j, 4'h6, 1, 0);
    for (int j = 0; j < 8; j++) push(1, 32'h200 + j, 4'h7, 1, 0);
    drive();
    run_until(17, 80, "t5");
    if (out_q.size() == 17)
      for (int p = 0; p < 17; p++) begin
        check("t5_order", out_q[p].data, (p % 2) ? 32'h200 + (p - 1) / 2 : 32'h100 + p / 2);
        check("t5_last", out_q[p].last, 1);
      end
    check("t5_pkt_cnt_wrap", pkt_cnt, 1);

    // Reset during beat 2 of 4, then both request together.
    out_q.delete();
    pkt(0, 32'hF1, 4, 4'h1);
    drive();
    c0 = 0;
    while (out_q.size() < 1 && c0 < 10) begin
      cycle();
      c0++;
    end
    check("t6_first_beat", out_q.size(), 1);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    flush();
    drive();
    check("t6_rst_m_tvalid", m_tvalid, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_pkt_cnt", pkt_cnt, 0);
    out_q.delete();
    push(0, 32'h31, 4'h1, 1, 0);
    push(1, 32'h41, 4'h2, 1, 0);
    drive();
    run_until(2, 20, "t6");
    if (out_q.size() == 2) begin
      check("t6_prio0", out_q[0].data, 32'h31);
      check("t6_then1", out_q[1].data, 32'h41);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
